// File: rtl/rv32i_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_ctrl_pkg
// Brief    : Shared state encoding and constants for the fetch load controller.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_fetch_ctrl_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2,
    S_ACK_GAP = 3'd3,
    S_FLUSH   = 3'd4,
    S_RUN     = 3'd5,
    S_ERROR   = 3'd6
  } fetch_load_state_e;

endpackage
`default_nettype wire

// File: rtl/rv32i_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_timeout_counter
// Brief    : Loadable down-counter; o_expired is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_timeout_counter #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_value;
    end else if (i_enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rv32i_fetch_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_load_controller
// Brief    : Streams a program image into fetch-stage instruction memory, then
//            releases the fetch reset and gates decode-ready until load is good.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_fetch_load_controller
  import rv32i_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned MAX_WORDS   = 512,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned RST_CYCLES  = 2,
  localparam int unsigned LEN_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_start,
  input  logic [LEN_W-1:0] i_load_length,
  input  logic             i_load_valid,
  input  logic [31:0]      i_load_data,
  output logic             o_load_ready,
  output logic             o_instruction_wr_en,
  output logic [31:0]      o_instruction_wr_addr,
  output logic [31:0]      o_instruction_wr_data,
  input  logic             i_instruction_wr_valid,
  output logic             o_fetch_rst,
  input  logic             i_decode_ready,
  output logic             o_decode_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [LEN_W-1:0] o_load_count
);

  localparam int unsigned TMR_MAX = (ACK_TIMEOUT > RST_CYCLES) ? ACK_TIMEOUT : RST_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  fetch_load_state_e state_q;
  fetch_load_state_e state_d;

  logic [LEN_W-1:0] length_q;
  logic [LEN_W-1:0] count_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             done_q;

  logic             start_ok;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_enable;
  logic             tmr_expired;

  assign start_ok = i_load_start &&
                    ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERROR));

  // One shared timer: ack watch while in WRITE, reset-pulse width while in FLUSH.
  assign tmr_enable = (state_q == S_WRITE) || (state_q == S_FLUSH);

  rv32i_timeout_counter #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (tmr_load),
    .i_load_value (tmr_value),
    .i_enable     (tmr_enable),
    .o_expired    (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (i_load_start) begin
          if (i_load_length > LEN_W'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else if (i_load_length == '0) begin
            state_d   = S_FLUSH;
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(RST_CYCLES - 1);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (i_load_valid) begin
          state_d   = S_WRITE;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(ACK_TIMEOUT - 1);
        end
      end
      S_WRITE: begin
        // An ack in the final allowed cycle still counts as a good write.
        if (i_instruction_wr_valid) begin
          state_d = S_ACK_GAP;
        end else if (tmr_expired) begin
          state_d = S_ERROR;
        end
      end
      S_ACK_GAP: begin
        if (count_q == length_q) begin
          state_d   = S_FLUSH;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(RST_CYCLES - 1);
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (tmr_expired) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FLUSH) && tmr_expired;
      if (start_ok) begin
        length_q <= i_load_length;
        count_q  <= '0;
        addr_q   <= BASE_ADDR;
      end else begin
        if ((state_q == S_LOAD) && i_load_valid) begin
          data_q <= i_load_data;
        end
        if ((state_q == S_WRITE) && i_instruction_wr_valid) begin
          count_q <= count_q + LEN_W'(1);
          addr_q  <= addr_q + 32'(INSTR_BYTES);
        end
      end
    end
  end

  assign o_load_ready          = (state_q == S_LOAD);
  assign o_instruction_wr_en   = (state_q == S_WRITE);
  assign o_instruction_wr_addr = addr_q;
  assign o_instruction_wr_data = data_q;
  assign o_fetch_rst           = (state_q != S_RUN);
  assign o_decode_ready        = (state_q == S_RUN) && i_decode_ready;
  assign o_busy                = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                                 (state_q == S_ACK_GAP) || (state_q == S_FLUSH);
  assign o_done                = done_q;
  assign o_error               = (state_q == S_ERROR);
  assign o_load_count          = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_fetch_load_controller
// Brief    : Directed scoreboard bench for the fetch load controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch_load_controller;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [9:0]  load_length = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        wr_ack = 1'b0;
  logic        dec_rdy_in = 1'b0;

  logic        o_load_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_fetch_rst;
  logic        o_decode_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [9:0]  o_load_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] src_q[$];
  wr_t         exp_q[$];
  wr_t         exp_e;
  bit          pop_pending = 1'b0;
  bit          ack_block = 1'b0;
  logic [31:0] delay_addr = 32'hFFFF_FFFF;
  int          delay_cycles = 0;
  int          ack_cnt = 0;
  bit          prev_wr_en = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  rv32i_fetch_load_controller dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_load_start           (load_start),
    .i_load_length          (load_length),
    .i_load_valid           (load_valid),
    .i_load_data            (load_data),
    .o_load_ready           (o_load_ready),
    .o_instruction_wr_en    (o_wr_en),
    .o_instruction_wr_addr  (o_wr_addr),
    .o_instruction_wr_data  (o_wr_data),
    .i_instruction_wr_valid (wr_ack),
    .o_fetch_rst            (o_fetch_rst),
    .i_decode_ready         (dec_rdy_in),
    .o_decode_ready         (o_decode_ready),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_error                (o_error),
    .o_load_count           (o_load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word source, fetch-stage ack model and write scoreboard, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pending && (src_q.size() > 0)) src_q.delete(0);
      if (src_q.size() > 0) begin
        load_valid = 1'b1;
        load_data  = src_q[0];
      end else begin
        load_valid = 1'b0;
      end
      pop_pending = load_valid && o_load_ready;

      if (o_wr_en) begin
        wr_ack = !ack_block &&
                 (ack_cnt >= ((o_wr_addr == delay_addr) ? delay_cycles : 0));
        ack_cnt++;
      end else begin
        wr_ack  = 1'b0;
        ack_cnt = 0;
      end

      if (prev_ack) check("gap_after_ack", 32'(o_wr_en), 0);
      if (o_wr_en && prev_wr_en && !prev_ack) begin
        check("held_addr", o_wr_addr, prev_addr);
        check("held_data", o_wr_data, prev_data);
      end
      if (o_wr_en && wr_ack) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", o_wr_addr, o_wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", o_wr_addr, exp_e.addr);
          check("wr_data", o_wr_data, exp_e.data);
        end
      end
      prev_wr_en = o_wr_en;
      prev_ack   = o_wr_en && wr_ack;
      prev_addr  = o_wr_addr;
      prev_data  = o_wr_data;
    end
  end

  // Called on a falling edge; returns on the falling edge after the start is taken.
  task automatic start_load(input int len, input logic [31:0] dseed, input int nsrc, input int nexp);
    for (int i = 0; i < nsrc; i++) src_q.push_back(dseed + 32'(4 * i));
    for (int i = 0; i < nexp; i++) begin
      wr_t e;
      e.addr = 32'(4 * i);
      e.data = dseed + 32'(4 * i);
      exp_q.push_back(e);
    end
    load_length = 10'(len);
    load_start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Cycle count includes the cycle in which the start was sampled.
  task automatic wait_done(input string name, input int exp_cycles);
    int k = 1;
    while (!o_done && (k < 500)) begin
      @(negedge clk);
      k++;
    end
    check({name, "_cycles"}, 32'(k), 32'(exp_cycles));
    check({name, "_fetch_rst"}, 32'(o_fetch_rst), 0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(o_done), 0);
    check({name, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int k;
    bit seen;

    dec_rdy_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_fetch_rst", 32'(o_fetch_rst), 1);
    check("rst_wr_en", 32'(o_wr_en), 0);
    check("rst_wr_addr", o_wr_addr, 32'h0);
    check("rst_decode_ready", 32'(o_decode_ready), 0);
    check("rst_busy_done_err", {29'd0, o_busy, o_done, o_error}, 0);
    check("rst_count", 32'(o_load_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four words, single-cycle acks: 1 + 3*4 + 2 cycles to RUN.
    start_load(4, 32'h0, 4, 4);
    check("t1_load_ready", 32'(o_load_ready), 1);
    check("t1_busy", 32'(o_busy), 1);
    wait_done("t1", 15);
    check("t1_count", 32'(o_load_count), 4);
    dec_rdy_in = 1'b0;
    #1 check("t1_dec_follow_lo", 32'(o_decode_ready), 0);
    dec_rdy_in = 1'b1;
    #1 check("t1_dec_follow_hi", 32'(o_decode_ready), 1);
    @(negedge clk);

    // Second word acked after 5 extra WRITE cycles; restart taken from RUN.
    delay_addr   = 32'h4;
    delay_cycles = 5;
    start_load(4, 32'hA000_0000, 4, 4);
    check("t2_dec_gated", 32'(o_decode_ready), 0);
    check("t2_fetch_rst", 32'(o_fetch_rst), 1);
    wait_done("t2", 20);
    check("t2_count", 32'(o_load_count), 4);
    delay_addr = 32'hFFFF_FFFF;

    // Ack withheld: the 64th WRITE cycle is the last one before ERROR.
    ack_block = 1'b1;
    start_load(2, 32'hB000_0000, 1, 0);
    k = 0;
    while (!o_wr_en && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    check("t3_write_entered", 32'(o_wr_en), 1);
    repeat (63) @(negedge clk);
    check("t3_err_before_limit", 32'(o_error), 0);
    check("t3_wr_en_at_limit", 32'(o_wr_en), 1);
    @(negedge clk);
    check("t3_error", 32'(o_error), 1);
    check("t3_fetch_rst", 32'(o_fetch_rst), 1);
    check("t3_wr_en_off", 32'(o_wr_en), 0);
    repeat (3) @(negedge clk);
    check("t3_error_sticky", 32'(o_error), 1);
    ack_block = 1'b0;
    start_load(1, 32'hB100_0000, 1, 1);
    check("t3_error_cleared", 32'(o_error), 0);
    wait_done("t3r", 6);
    check("t3r_count", 32'(o_load_count), 1);

    // Zero length: straight to FLUSH, no write.
    start_load(0, 32'h0, 0, 0);
    check("t4_flush_busy", 32'(o_busy), 1);
    check("t4_flush_rst", 32'(o_fetch_rst), 1);
    wait_done("t4", 3);
    check("t4_count", 32'(o_load_count), 0);

    // Oversize length: immediate ERROR, no write at all.
    start_load(600, 32'h0, 0, 0);
    check("t5_error", 32'(o_error), 1);
    check("t5_busy", 32'(o_busy), 0);
    seen = 1'b0;
    repeat (10) begin
      if (o_wr_en) seen = 1'b1;
      @(negedge clk);
    end
    check("t5_no_wr_en", 32'(seen), 0);

    // Recover from ERROR, then reload from RUN.
    start_load(2, 32'hC000_0000, 2, 2);
    wait_done("t6a", 9);
    check("t6a_count", 32'(o_load_count), 2);
    check("t6_dec_before", 32'(o_decode_ready), 1);
    start_load(2, 32'hD000_0000, 2, 2);
    check("t6_dec_after_start", 32'(o_decode_ready), 0);
    wait_done("t6b", 9);
    check("t6b_count", 32'(o_load_count), 2);

    // Asynchronous reset while the second word is being written.
    start_load(4, 32'hE000_0000, 4, 4);
    k = 0;
    while (!(o_wr_en && (o_wr_addr == 32'h4)) && (k < 50)) begin
      @(negedge clk);
      k++;
    end
    check("t7_mid_write", 32'(o_wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_fetch_rst", 32'(o_fetch_rst), 1);
    check("t7_wr_en", 32'(o_wr_en), 0);
    check("t7_wr_addr", o_wr_addr, 32'h0);
    check("t7_count", 32'(o_load_count), 0);
    check("t7_ready_dec", {30'd0, o_load_ready, o_decode_ready}, 0);
    check("t7_busy_done_err", {29'd0, o_busy, o_done, o_error}, 0);
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
